mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  Load/store unit in the MEM stage. It consumes the memory op, effective address and store
//  data latched by the EX/MEM pipeline register and starts a single-beat req/ack transfer on
//  the data bus. It stalls the pipeline until the bus responds.
//  Handles byte-lane steering, load sign/zero extension and alignment faults (AdEL/AdES).
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in BUSY without bus_ack_i before bus error (only with LSU_TIMEOUT_EN)
//  CNT_W           8    width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk           in   1   clock
//  rst           in   1   reset, synchronous, active-high
//  op_valid_i    in   1   op_i/addr_i/wdata_i valid this cycle
//  op_i          in   4   0 NONE,1 LB,2 LBU,3 LH,4 LHU,5 LW,9 SB,10 SH,11 SW; other codes = NONE
//  addr_i        in   32  effective byte address
//  wdata_i       in   32  store data (rt value)
//  flush_i       in   1   pipeline flush (exception/eret)
//  stall_o       out  1   stall request to pipeline control
//  done_o        out  1   load/store completed; rdata_o valid for loads
//  rdata_o       out  32  extended load result
//  adel_o        out  1   load address misaligned (combinational)
//  ades_o        out  1   store address misaligned (combinational)
//  bus_err_o     out  1   transfer timed out (0 when LSU_TIMEOUT_EN undefined)
//  bus_req_o     out  1   bus request
//  bus_we_o      out  1   1 = write
//  bus_be_o      out  4   byte enables
//  bus_addr_o    out  32  word address {addr[31:2],2'b00}
//  bus_wdata_o   out  32  lane-replicated store data
//  bus_rdata_i   in   32  read data, valid in the bus_ack_i cycle
//  bus_ack_i     in   1   transfer complete; sampled only while bus_req_o=1
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; abort flag 0; timeout counter 0.
//  Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
//   - Raises adel_o (loads) or ades_o (stores) in the same cycle, only when op_valid_i=1 and flush_i=0.
//   - No bus request is made and stall_o stays 0.
//  FSM:
//   - IDLE: a valid, aligned, non-NONE op with flush_i=0 does the following.
//     - Registers bus_addr/be/we/wdata.
//     - Sets bus_req_o=1 at the next edge and moves to BUSY.
//     - stall_o=1 combinationally in this same cycle.
//   - BUSY: bus_req_o=1; stall_o=1; bus outputs held stable until the ack cycle.
//     - On bus_ack_i with abort=0: capture the extended bus_rdata_i into rdata_o, drop bus_req_o, go to DONE.
//     - On bus_ack_i with abort=1: drop bus_req_o, go to IDLE, rdata_o unchanged, no done_o.
//   - DONE: done_o=1 for one cycle; stall_o=0 so EX/MEM advances; input op ignored; then IDLE.
//  Latency: op seen in cycle N; request in N+1; ack in cycle M; done_o in M+1; earliest M=N+1.
//   - At least one idle bus cycle between transfers.
//  flush_i in BUSY: the bus cycle cannot be cancelled. Set abort=1 and keep stall_o=1 until
//   the ack, then discard the result. flush_i in DONE: done_o still pulses.
//  Lanes (a=addr[1:0]):
//   - SB: be=4'b0001<<a, wdata={4{wd[7:0]}}.
//   - SH: be=a[1]?4'b1100:4'b0011, wdata={2{wd[15:0]}}.
//   - SW: be=4'b1111, wdata=wd.
//   - Loads use the same be; bus_we_o=0.
//   - LB/LH sign-extend and LBU/LHU zero-extend the selected lane; LW passes through.
//  bus_ack_i while bus_req_o=0 is ignored. rst mid-transfer: immediate IDLE, req dropped.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined:
//   - Counter clears on entry to BUSY and increments each BUSY cycle without ack.
//   - When it reaches TIMEOUT_CYCLES: drop bus_req_o and go to DONE with bus_err_o=1 and rdata_o=0.
//   - bus_err_o is valid with done_o. A timeout while abort=1 goes to IDLE with no error.
//   - An ack in the same cycle as the timeout wins.
//  LSU_TIMEOUT_EN undefined: no counter; BUSY waits forever; bus_err_o tied 0.
// TESTING
//  1 LW addr=0x1000, ack 3 cycles later, rdata=0xDEADBEEF
//    -> be=1111, we=0, stall 5 cycles, done_o 1 cycle, rdata_o=0xDEADBEEF.
//  2 LB addr=0x1003, rdata=0x80123456 -> be=1000, rdata_o=0xFFFFFF80.
//    Same with LBU -> rdata_o=0x00000080.
//  3 SH addr=0x2002, wdata=0x1234ABCD -> be=1100, bus_wdata=0xABCDABCD, we=1, bus_addr=0x2000.
//  4 LW addr=0x1001 -> adel_o=1 same cycle, no bus_req_o, stall_o=0.
//    SH addr=0x3 -> ades_o=1.
//  5 LW issued, flush_i in first BUSY cycle, ack 2 cycles later
//    -> req held until ack, no done_o, rdata_o unchanged.
//  6 (LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4) LW with no ack
//    -> req drops after 4 BUSY cycles, done_o=1, bus_err_o=1, rdata_o=0.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving a single-beat req/ack data bus.
// Optional macro LSU_TIMEOUT_EN adds a bus timeout that ends a stuck transfer with bus_err_o.
module mem_lsu #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    // Bus handshake: bus_req_o rises one edge after the op is accepted and the address,
    // byte enables, write flag and data stay frozen until the cycle bus_ack_i=1 is seen
    // with bus_req_o=1; req drops at the following edge. Acks with req low are ignored.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic        is_load;
    logic        is_store;
    logic        size_half;
    logic        size_word;
    logic        misaligned;
    logic        start;
    logic [3:0]  be;
    logic [31:0] lanes;
    logic [3:0]  op_q;
    logic [1:0]  off_q;
    logic        abort;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext;

    if (TIMEOUT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
        $error("mem_lsu: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        size_half = 1'b0;
        size_word = 1'b0;
        case (op_i)
            4'd1, 4'd2: is_load = 1'b1;
            4'd3, 4'd4: begin is_load = 1'b1; size_half = 1'b1; end
            4'd5:       begin is_load = 1'b1; size_word = 1'b1; end
            4'd9:       is_store = 1'b1;
            4'd10:      begin is_store = 1'b1; size_half = 1'b1; end
            4'd11:      begin is_store = 1'b1; size_word = 1'b1; end
            default:    ;
        endcase
    end

    assign misaligned = (size_half & addr_i[0]) | (size_word & (|addr_i[1:0]));
    assign adel_o     = op_valid_i & ~flush_i & is_load  & misaligned;
    assign ades_o     = op_valid_i & ~flush_i & is_store & misaligned;
    assign start      = (state == IDLE) & op_valid_i & ~flush_i
                        & (is_load | is_store) & ~misaligned;
    assign stall_o    = start | (state == BUSY);

    always_comb begin
        if (size_word) begin
            be    = 4'b1111;
            lanes = wdata_i;
        end else if (size_half) begin
            be    = addr_i[1] ? 4'b1100 : 4'b0011;
            lanes = {2{wdata_i[15:0]}};
        end else begin
            be    = 4'b0001 << addr_i[1:0];
            lanes = {4{wdata_i[7:0]}};
        end
    end

    // Load extension works on the op and byte offset latched at issue time.
    assign byte_sel = bus_rdata_i[{off_q, 3'b000} +: 8];
    assign half_sel = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

    always_comb begin
        case (op_q)
            4'd1:    ext = {{24{byte_sel[7]}}, byte_sel};
            4'd2:    ext = {24'd0, byte_sel};
            4'd3:    ext = {{16{half_sel[15]}}, half_sel};
            4'd4:    ext = {16'd0, half_sel};
            default: ext = bus_rdata_i;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic             bus_err;
    logic             expired;

    // expired marks the TIMEOUT_CYCLES-th BUSY cycle without an ack.
    assign expired   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err_o = bus_err;
`else
    assign bus_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_be_o    <= 4'd0;
            bus_addr_o  <= 32'd0;
            bus_wdata_o <= 32'd0;
            rdata_o     <= 32'd0;
            done_o      <= 1'b0;
            abort       <= 1'b0;
            op_q        <= 4'd0;
            off_q       <= 2'd0;
`ifdef LSU_TIMEOUT_EN
            cnt         <= '0;
            bus_err     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= is_store;
                        bus_be_o    <= be;
                        bus_addr_o  <= {addr_i[31:2], 2'b00};
                        bus_wdata_o <= lanes;
                        op_q        <= op_i;
                        off_q       <= addr_i[1:0];
                        abort       <= 1'b0;
                        state       <= BUSY;
`ifdef LSU_TIMEOUT_EN
                        cnt         <= '0;
`endif
                    end
                end
                BUSY: begin
                    // The bus cycle cannot be withdrawn; a flush only marks the result as dead.
                    if (flush_i) abort <= 1'b1;
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        abort     <= 1'b0;
                        if (abort | flush_i) begin
                            state <= IDLE;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            if (!bus_we_o) rdata_o <= ext;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else begin
                        cnt <= cnt + 1'b1;
                        if (expired) begin
                            bus_req_o <= 1'b0;
                            abort     <= 1'b0;
                            if (abort | flush_i) begin
                                state <= IDLE;
                            end else begin
                                state   <= DONE;
                                done_o  <= 1'b1;
                                bus_err <= 1'b1;
                                rdata_o <= 32'd0;
                            end
                        end
                    end
`endif
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
`ifdef LSU_TIMEOUT_EN
                    bus_err <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu with a spec-level model of lanes, extension and timing.
module tb_mem_lsu;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd9;
    localparam logic [3:0] OP_SH   = 4'd10;
    localparam logic [3:0] OP_SW   = 4'd11;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid_i;
    logic [3:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        adel_o;
    logic        ades_o;
    logic        bus_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    mem_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid_i  (op_valid_i),
        .op_i        (op_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .adel_o      (adel_o),
        .ades_o      (ades_o),
        .bus_err_o   (bus_err_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_be_o    (bus_be_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i)
    );

    always #5 clk = ~clk;

    int          n_checks    = 0;
    int          n_fail      = 0;
    int          stall_seen  = 0;
    logic        chk_on      = 1'b0;
    logic        exp_stall   = 1'b0;
    logic        exp_req     = 1'b0;
    logic        exp_done    = 1'b0;
    logic        exp_adel    = 1'b0;
    logic        exp_ades    = 1'b0;
    logic        exp_we      = 1'b0;
    logic [3:0]  exp_be      = 4'd0;
    logic [31:0] exp_addr    = 32'd0;
    logic [31:0] exp_wdata   = 32'd0;
    logic [31:0] exp_rdata   = 32'd0;
    logic        rdata_known = 1'b1;
    logic [32:0] exp_q[$];
    logic [32:0] ent;

    // ---------------- model ----------------
    function automatic int size_of(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [31:0] addr);
        int sz = size_of(op);
        return (sz != 0) && ((int'(addr[1:0]) % sz) != 0);
    endfunction

    function automatic logic [3:0] be_of(input logic [3:0] op, input logic [31:0] addr);
        int sz = size_of(op);
        int base = int'(addr[1:0]) / sz * sz;
        return 4'(((1 << sz) - 1) << base);
    endfunction

    function automatic logic [31:0] wdata_of(input logic [3:0] op, input logic [31:0] wd);
        case (size_of(op))
            1:       return 32'(wd[7:0]) * 32'h0101_0101;
            2:       return 32'(wd[15:0]) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ext_of(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
        int     sz = size_of(op);
        int     base;
        longint v;
        if (sz == 0) return rd;
        base = int'(addr[1:0]) / sz * sz;
        v = longint'(rd >> (8 * base)) & ((64'd1 << (8 * sz)) - 1);
        if ((op == OP_LB || op == OP_LH) && v >= longint'(64'd1 << (8 * sz - 1)))
            v = v - longint'(64'd1 << (8 * sz));
        return 32'(v);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (stall_o) stall_seen++;
            check("stall_o",   32'(stall_o),   32'(exp_stall));
            check("bus_req_o", 32'(bus_req_o), 32'(exp_req));
            check("done_o",    32'(done_o),    32'(exp_done));
            check("adel_o",    32'(adel_o),    32'(exp_adel));
            check("ades_o",    32'(ades_o),    32'(exp_ades));
            check("bus_err_o", 32'(bus_err_o), 32'd0);
            if (rdata_known) check("rdata_o", rdata_o, exp_rdata);
            if (exp_req) begin
                check("bus_we_o",   32'(bus_we_o), 32'(exp_we));
                check("bus_be_o",   32'(bus_be_o), 32'(exp_be));
                check("bus_addr_o", bus_addr_o,    exp_addr);
                if (exp_we) check("bus_wdata_o", bus_wdata_o, exp_wdata);
            end
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_scoreboard: done_o=1 with no completion expected at %0t", $time);
                end else begin
                    ent = exp_q.pop_front();
                    if (ent[32]) check("done_rdata", rdata_o, ent[31:0]);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One load/store: ack_dly extra BUSY cycles before the ack, optional flush in BUSY
    // cycle flush_at (negative = none) or in the done cycle. lit_be/lit_val pin the model.
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int ack_dly, input int flush_at,
                         input logic flush_done, input logic [3:0] lit_be,
                         input logic [31:0] lit_val);
        logic        ld;
        logic        aborted;
        logic [31:0] res;
        ld  = is_load(op);
        res = ext_of(op, addr, rd);
        check("pin_be", 32'(be_of(op, addr)), 32'(lit_be));
        if (ld) check("pin_ext", res, lit_val);
        else    check("pin_wdata", wdata_of(op, wd), lit_val);

        op_valid_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd;
        exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0;
        exp_we = !ld; exp_be = be_of(op, addr); exp_addr = {addr[31:2], 2'b00};
        exp_wdata = wdata_of(op, wd);
        stall_seen = 0;
        aborted = 1'b0;
        next_cycle();

        for (int k = 0; k <= ack_dly; k++) begin
            exp_req = 1'b1; exp_stall = 1'b1;
            flush_i = (k == flush_at);
            if (k == flush_at) aborted = 1'b1;
            if (flush_at >= 0 && k > flush_at) op_valid_i = 1'b0;
            bus_ack_i = (k == ack_dly);
            bus_rdata_i = (k == ack_dly) ? rd : $urandom;
            next_cycle();
        end

        flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = $urandom;
        exp_req = 1'b0; exp_stall = 1'b0;
        if (!aborted) begin
            exp_done = 1'b1;
            flush_i = flush_done;
            if (ld) begin exp_rdata = res; rdata_known = 1'b1; end
            else    rdata_known = 1'b0;
            exp_q.push_back({ld, res});
            next_cycle();
        end
        op_valid_i = 1'b0; flush_i = 1'b0; exp_done = 1'b0;
        next_cycle();
        check("stall_cycles", 32'(stall_seen), 32'(ack_dly + 2));
    endtask

    task automatic do_misaligned(input logic [3:0] op, input logic [31:0] addr);
        check("pin_misaligned", 32'(misaligned(op, addr)), 32'd1);
        op_valid_i = 1'b1; op_i = op; addr_i = addr; wdata_i = $urandom;
        exp_adel = is_load(op); exp_ades = !is_load(op);
        exp_stall = 1'b0; exp_req = 1'b0;
        next_cycle();
        op_valid_i = 1'b0; exp_adel = 1'b0; exp_ades = 1'b0;
        next_cycle();
    endtask

    task automatic quiet_cycle(input logic v, input logic [3:0] op, input logic [31:0] addr,
                               input logic fl, input logic ack);
        op_valid_i = v; op_i = op; addr_i = addr; flush_i = fl; bus_ack_i = ack;
        bus_rdata_i = $urandom;
        exp_stall = 1'b0; exp_req = 1'b0; exp_adel = 1'b0; exp_ades = 1'b0;
        next_cycle();
        op_valid_i = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b0;
        next_cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; op_valid_i = 1'b0; op_i = OP_NONE; addr_i = 32'd0; wdata_i = 32'd0;
        flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
        next_cycle();
        chk_on = 1'b1;
        check("rst_bus_we",    32'(bus_we_o), 32'd0);
        check("rst_bus_be",    32'(bus_be_o), 32'd0);
        check("rst_bus_addr",  bus_addr_o,    32'd0);
        check("rst_bus_wdata", bus_wdata_o,   32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        do_op(OP_LW,  32'h0000_1000, 32'h0,         32'hDEAD_BEEF, 3, -1, 1'b0, 4'b1111, 32'hDEAD_BEEF);
        do_op(OP_LB,  32'h0000_1003, 32'h0,         32'h8012_3456, 0, -1, 1'b0, 4'b1000, 32'hFFFF_FF80);
        do_op(OP_LBU, 32'h0000_1003, 32'h0,         32'h8012_3456, 0, -1, 1'b0, 4'b1000, 32'h0000_0080);
        do_op(OP_SH,  32'h0000_2002, 32'h1234_ABCD, 32'h0,         1, -1, 1'b0, 4'b1100, 32'hABCD_ABCD);
        do_op(OP_SB,  32'h0000_2001, 32'h0000_00A5, 32'h0,         2, -1, 1'b0, 4'b0010, 32'hA5A5_A5A5);
        do_op(OP_SW,  32'h0000_2004, 32'hCAFE_F00D, 32'h0,         0, -1, 1'b0, 4'b1111, 32'hCAFE_F00D);
        do_op(OP_LH,  32'h0000_1002, 32'h0,         32'h8001_7FFF, 1, -1, 1'b0, 4'b1100, 32'hFFFF_8001);
        do_op(OP_LHU, 32'h0000_1000, 32'h0,         32'h8001_F00D, 0, -1, 1'b0, 4'b0011, 32'h0000_F00D);
        do_op(OP_LB,  32'h0000_1001, 32'h0,         32'h0000_7F00, 0, -1, 1'b0, 4'b0010, 32'h0000_007F);
        // flushed in the first BUSY cycle: req held to the ack, result dropped
        do_op(OP_LW,  32'h0000_4004, 32'h0,         32'h5555_5555, 2,  0, 1'b0, 4'b1111, 32'h5555_5555);
        check("abort_keeps_rdata", rdata_o, 32'h0000_007F);
        // flush during the done cycle still lets done_o pulse
        do_op(OP_LW,  32'h0000_0010, 32'h0,         32'h0BAD_CAFE, 1, -1, 1'b1, 4'b1111, 32'h0BAD_CAFE);

        do_misaligned(OP_LW,  32'h0000_1001);
        do_misaligned(OP_SH,  32'h0000_0003);
        do_misaligned(OP_LHU, 32'h0000_0005);
        do_misaligned(OP_SW,  32'h0000_0002);

        quiet_cycle(1'b1, OP_NONE, 32'h0000_0100, 1'b0, 1'b0);
        quiet_cycle(1'b1, 4'd7,    32'h0000_0101, 1'b0, 1'b0);
        quiet_cycle(1'b1, 4'd15,   32'h0000_0100, 1'b0, 1'b0);
        quiet_cycle(1'b1, OP_LW,   32'h0000_0200, 1'b1, 1'b0);
        quiet_cycle(1'b1, OP_LW,   32'h0000_0201, 1'b1, 1'b0);
        quiet_cycle(1'b0, OP_SW,   32'h0000_0003, 1'b0, 1'b0);
        quiet_cycle(1'b0, OP_LW,   32'h0000_0200, 1'b0, 1'b1);

        // reset in the middle of a transfer
        op_valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h0000_5000; wdata_i = 32'h0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_be = 4'b1111;
        exp_addr = 32'h0000_5000;
        next_cycle();
        exp_req = 1'b1;
        next_cycle();
        rst = 1'b1; op_valid_i = 1'b0;
        next_cycle();
        rst = 1'b0; exp_req = 1'b0; exp_stall = 1'b0; exp_rdata = 32'd0; rdata_known = 1'b1;
        bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
        next_cycle();
        bus_ack_i = 1'b0;
        next_cycle();
        next_cycle();

        chk_on = 1'b0;
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
